decode_stage: RTL and testbench

- Instruction-decode (ID) stage of a 5-stage pipelined MIPS core with word-addressed PC.
- Contains the 32x32 register file, the main and ALU control decoder, sign extension, and early branch resolution with forwarding muxes.
- Contains the ID/EX pipeline register that feeds the execute stage; the register supports flush.

---
 rtl/decode_stage.sv | 191 +++++++++++++++++++
 tb/tb_decode_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with register file, decoder, early branch, ID/EX register.
// Optional WGHT_EN: enables the WGHT R-type op (funct 111111) and the RF[Rd] read port.
module decode_stage #(
  parameter int PC_SIZE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        InstrD,
  input  logic [PC_SIZE-1:0] PCPlus1D,
  input  logic               ForwardAD,
  input  logic               ForwardBD,
  input  logic               FlushE,
  input  logic [31:0]        ALUOutM,
  input  logic [31:0]        ResultW,
  input  logic               RegWriteW,
  input  logic [4:0]         WriteRegW,
  output logic [31:0]        RD1E,
  output logic [31:0]        RD2E,
  output logic [31:0]        RD3E,
  output logic               BranchD,
  output logic [4:0]         RsD,
  output logic [4:0]         RtD,
  output logic [4:0]         RdD,
  output logic [2:0]         ALUControlD,
  output logic               PCSrcD,
  output logic [PC_SIZE-1:0] PCBranchD,
  output logic [4:0]         RsE,
  output logic [4:0]         RtE,
  output logic [4:0]         RdE,
  output logic [31:0]        SignImmE,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               ALUSrcE,
  output logic               RegDstE,
  output logic [2:0]         ALUControlE
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;

  logic [31:0] regFile [32];
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] signImm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        rKnown;
  logic [2:0]  rAlu;
  logic        regWriteD;
  logic        memtoRegD;
  logic        memWriteD;
  logic        aluSrcD;
  logic        regDstD;

  assign op      = InstrD[31:26];
  assign funct   = InstrD[5:0];
  assign RsD     = InstrD[25:21];
  assign RtD     = InstrD[20:16];
  assign RdD     = InstrD[15:11];
  assign signImm = {{16{InstrD[15]}}, InstrD[15:0]};

  // Register file: r0 is never written; reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (RegWriteW && WriteRegW != 5'd0) begin
      regFile[WriteRegW] <= ResultW;
    end
  end

  // Reads bypass the write port so a same-cycle write is seen immediately.
  assign rd1 = (RsD == 5'd0) ? '0 :
               (RegWriteW && WriteRegW == RsD) ? ResultW : regFile[RsD];
  assign rd2 = (RtD == 5'd0) ? '0 :
               (RegWriteW && WriteRegW == RtD) ? ResultW : regFile[RtD];

`ifdef WGHT_EN
  logic [31:0] rd3;
  assign rd3 = (RdD == 5'd0) ? '0 :
               (RegWriteW && WriteRegW == RdD) ? ResultW : regFile[RdD];
`endif

  // R-type function decode; unknown functs disable all controls.
  always_comb begin
    rKnown = 1'b1;
    rAlu   = 3'b000;
    unique case (funct)
      6'b100000: rAlu = 3'b010;
      6'b100010: rAlu = 3'b110;
      6'b100100: rAlu = 3'b000;
      6'b100101: rAlu = 3'b001;
      6'b101010: rAlu = 3'b111;
`ifdef WGHT_EN
      6'b111111: rAlu = 3'b011;
`endif
      default:   rKnown = 1'b0;
    endcase
  end

  // Main opcode decoder.
  always_comb begin
    regWriteD   = 1'b0;
    memtoRegD   = 1'b0;
    memWriteD   = 1'b0;
    aluSrcD     = 1'b0;
    regDstD     = 1'b0;
    BranchD     = 1'b0;
    ALUControlD = 3'b000;
    unique case (1'b1)
      op == OpR: begin
        regWriteD   = rKnown;
        regDstD     = rKnown;
        ALUControlD = rAlu;
      end
      op == OpLw: begin
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        memtoRegD   = 1'b1;
        ALUControlD = 3'b010;
      end
      op == OpSw: begin
        memWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        ALUControlD = 3'b010;
      end
      op == OpBeq: begin
        BranchD     = 1'b1;
        ALUControlD = 3'b110;
      end
      op == OpAddi: begin
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        ALUControlD = 3'b010;
      end
      default: ;
    endcase
  end

  assign srcA      = ForwardAD ? ALUOutM : rd1;
  assign srcB      = ForwardBD ? ALUOutM : rd2;
  assign PCSrcD    = BranchD & (srcA == srcB);
  assign PCBranchD = PCPlus1D + signImm[PC_SIZE-1:0];

  // ID/EX pipeline register; reset and flush both produce a bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      SignImmE    <= '0;
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= '0;
    end else begin
      RD1E        <= rd1;
      RD2E        <= rd2;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      SignImmE    <= signImm;
      RegWriteE   <= regWriteD;
      MemtoRegE   <= memtoRegD;
      MemWriteE   <= memWriteD;
      ALUSrcE     <= aluSrcD;
      RegDstE     <= regDstD;
      ALUControlE <= ALUControlD;
    end
  end

`ifdef WGHT_EN
  // Accumulator operand for the execute stage.
  always_ff @(posedge clk) begin
    if (reset || FlushE) RD3E <= '0;
    else                 RD3E <= rd3;
  end
`else
  assign RD3E = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table and random checks of decode_stage
// against a behavioural register-file and decode model.
module tb_decode_stage;
  localparam int PC_SIZE = 8;
`ifdef WGHT_EN
  localparam bit Wght = 1'b1;
`else
  localparam bit Wght = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [31:0]        InstrD;
  logic [PC_SIZE-1:0] PCPlus1D;
  logic               ForwardAD, ForwardBD, FlushE;
  logic [31:0]        ALUOutM, ResultW;
  logic               RegWriteW;
  logic [4:0]         WriteRegW;
  logic [31:0]        RD1E, RD2E, RD3E, SignImmE;
  logic               BranchD, PCSrcD;
  logic [4:0]         RsD, RtD, RdD, RsE, RtE, RdE;
  logic [2:0]         ALUControlD, ALUControlE;
  logic [PC_SIZE-1:0] PCBranchD;
  logic               RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;

  decode_stage #(.PC_SIZE(PC_SIZE)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus1D(PCPlus1D),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .FlushE(FlushE),
    .ALUOutM(ALUOutM), .ResultW(ResultW), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .RD1E(RD1E), .RD2E(RD2E), .RD3E(RD3E),
    .BranchD(BranchD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ALUControlD(ALUControlD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE)
  );

  typedef struct packed {
    logic rw, m2r, mw, src, dst, br;
    logic [2:0] alu;
  } ctrl_t;

  typedef struct {
    logic [31:0] rd1, rd2, rd3, imm;
    logic [4:0]  rs, rt, rd;
    ctrl_t       c;
  } eexp_t;

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  pc;
    logic        fa, fb;
    logic [31:0] alu;
    logic        br, src;
    logic [7:0]  pcb;
    logic [2:0]  ctl;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [32];
  eexp_t       expE;
  vec_t        vt [16];

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic ctrl_t expCtrl(input logic [31:0] ins);
    ctrl_t c;
    logic [5:0] o, f;
    o = ins[31:26];
    f = ins[5:0];
    c = '0;
    if (o == 6'h00) begin
      if (f == 6'h20) c = {6'b100010, 3'b010};
      else if (f == 6'h22) c = {6'b100010, 3'b110};
      else if (f == 6'h24) c = {6'b100010, 3'b000};
      else if (f == 6'h25) c = {6'b100010, 3'b001};
      else if (f == 6'h2a) c = {6'b100010, 3'b111};
      else if (f == 6'h3f && Wght) c = {6'b100010, 3'b011};
    end else if (o == 6'h23) c = {6'b110100, 3'b010};
    else if (o == 6'h2b) c = {6'b001100, 3'b010};
    else if (o == 6'h04) c = {6'b000001, 3'b110};
    else if (o == 6'h08) c = {6'b100100, 3'b010};
    return c;
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return mdl[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    eexp_t e;
    e.rd1 = '0; e.rd2 = '0; e.rd3 = '0; e.imm = '0;
    e.rs = '0; e.rt = '0; e.rd = '0; e.c = '0;
    if (!(reset || FlushE)) begin
      e.rd1 = mRead(InstrD[25:21]);
      e.rd2 = mRead(InstrD[20:16]);
      e.rd3 = Wght ? mRead(InstrD[15:11]) : 32'd0;
      e.imm = {{16{InstrD[15]}}, InstrD[15:0]};
      e.rs  = InstrD[25:21];
      e.rt  = InstrD[20:16];
      e.rd  = InstrD[15:11];
      e.c   = expCtrl(InstrD);
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (RegWriteW && WriteRegW != 5'd0) begin
      mdl[WriteRegW] = ResultW;
    end
    expE = e;
    #1;
  endtask

  task automatic checkE(input string t);
    chk({t, ".RD1E"}, RD1E, expE.rd1);
    chk({t, ".RD2E"}, RD2E, expE.rd2);
    chk({t, ".RD3E"}, RD3E, expE.rd3);
    chk({t, ".SignImmE"}, SignImmE, expE.imm);
    chk({t, ".RsE"}, 32'(RsE), 32'(expE.rs));
    chk({t, ".RtE"}, 32'(RtE), 32'(expE.rt));
    chk({t, ".RdE"}, 32'(RdE), 32'(expE.rd));
    chk({t, ".ctrlE"},
        32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}),
        32'({expE.c.rw, expE.c.m2r, expE.c.mw, expE.c.src, expE.c.dst, expE.c.alu}));
  endtask

  task automatic checkD(input string t);
    ctrl_t c;
    logic [31:0] a, b, pcb;
    int off;
    c   = expCtrl(InstrD);
    a   = ForwardAD ? ALUOutM : mRead(InstrD[25:21]);
    b   = ForwardBD ? ALUOutM : mRead(InstrD[20:16]);
    off = int'($signed(InstrD[15:0]));
    pcb = 32'((int'(PCPlus1D) + off) & ((1 << PC_SIZE) - 1));
    chk({t, ".regsD"}, 32'({RsD, RtD, RdD}),
        32'({InstrD[25:21], InstrD[20:16], InstrD[15:11]}));
    chk({t, ".BranchD"}, 32'(BranchD), 32'(c.br));
    chk({t, ".ALUControlD"}, 32'(ALUControlD), 32'(c.alu));
    chk({t, ".PCSrcD"}, 32'(PCSrcD), 32'(c.br && (a == b)));
    chk({t, ".PCBranchD"}, 32'(PCBranchD), pcb);
  endtask

  initial begin
    logic [5:0] fns [7];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f, 6'h21};

    reset = 1'b1; InstrD = '0; PCPlus1D = '0; ForwardAD = 1'b0; ForwardBD = 1'b0;
    FlushE = 1'b0; ALUOutM = '0; ResultW = '0; RegWriteW = 1'b0; WriteRegW = '0;
    tick();
    tick();
    checkE("reset");
    chk("reset.RegWriteE", 32'(RegWriteE), 32'd0);

    reset = 1'b0;
    InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h3f);
    PCPlus1D = 8'd7;
    #1;
    chk("wght.regsD", 32'({RsD, RtD, RdD}), 32'({5'd1, 5'd2, 5'd3}));
    chk("wght.ALUControlD", 32'(ALUControlD), Wght ? 32'd3 : 32'd0);
    tick();
    chk("wght.RegWriteE", 32'(RegWriteE), 32'(Wght));
    chk("wght.RegDstE", 32'(RegDstE), 32'(Wght));
    chk("wght.ALUControlE", 32'(ALUControlE), Wght ? 32'd3 : 32'd0);
    chk("wght.regsE", 32'({RsE, RtE, RdE}), 32'({5'd1, 5'd2, 5'd3}));
    checkE("wght");

    InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd0;
    tick();
    WriteRegW = 5'd2; ResultW = 32'd10;
    tick();
    chk("wr.bypassRt", RD2E, 32'd10);
    WriteRegW = 5'd3; ResultW = 32'd20;
    tick();
    chk("wr.RD2E", RD2E, 32'd10);
    chk("wr.bypassRd", RD3E, Wght ? 32'd20 : 32'd0);
    checkE("wr");

    InstrD = rtype(5'd0, 5'd0, 5'd0, 6'h20);
    WriteRegW = 5'd0; ResultW = 32'd55;
    tick();
    chk("r0.bypass", RD1E, 32'd0);
    RegWriteW = 1'b0;
    tick();
    chk("r0.stored", RD1E, 32'd0);

    InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    FlushE = 1'b1;
    tick();
    checkE("flush");
    chk("flush.RD2E", RD2E, 32'd0);
    chk("flush.RegWriteE", 32'(RegWriteE), 32'd0);
    FlushE = 1'b0;
    tick();
    chk("reload.RD2E", RD2E, 32'd10);
    chk("reload.RtE", 32'(RtE), 32'd2);
    chk("reload.RegWriteE", 32'(RegWriteE), 32'd1);

    InstrD = itype(6'h08, 5'd1, 5'd4, 16'hFFFD);
    PCPlus1D = 8'd7;
    #1;
    chk("imm.PCBranchD", 32'(PCBranchD), 32'd4);
    tick();
    chk("imm.SignImmE", SignImmE, 32'hFFFFFFFD);

    InstrD = itype(6'h04, 5'd1, 5'd0, 16'hFFFD);
    #1;
    chk("beq.BranchD", 32'(BranchD), 32'd1);
    chk("beq.PCSrcD", 32'(PCSrcD), 32'd1);
    chk("beq.PCBranchD", 32'(PCBranchD), 32'd4);
    ForwardAD = 1'b1; ALUOutM = 32'd5;
    #1;
    chk("beqFwd.PCSrcD", 32'(PCSrcD), 32'd0);
    ForwardAD = 1'b0;

    InstrD = itype(6'h04, 5'd4, 5'd0, 16'h0000);
    ForwardBD = 1'b1; ALUOutM = 32'h99;
    RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'h99;
    #1;
    chk("beqBypass.PCSrcD", 32'(PCSrcD), 32'd1);
    RegWriteW = 1'b0;
    #1;
    chk("beqNoBypass.PCSrcD", 32'(PCSrcD), 32'd0);
    ForwardBD = 1'b0;

    vt[0]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h20), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h20, 3'b010};
    vt[1]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h22), 8'h10, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h32, 3'b110};
    vt[2]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h24), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h24, 3'b000};
    vt[3]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h25), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h25, 3'b001};
    vt[4]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h2a), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h2a, 3'b111};
    vt[5]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h21), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h21, 3'b000};
    vt[6]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h3f), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h3f,
               Wght ? 3'b011 : 3'b000};
    vt[7]  = '{itype(6'h23, 5'd1, 5'd2, 16'h0004), 8'hFE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h02, 3'b010};
    vt[8]  = '{itype(6'h2b, 5'd1, 5'd2, 16'h8000), 8'h05, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h05, 3'b010};
    vt[9]  = '{itype(6'h04, 5'd2, 5'd2, 16'h0001), 8'h10, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 8'h11, 3'b110};
    vt[10] = '{itype(6'h04, 5'd2, 5'd3, 16'hFFFF), 8'h00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 8'hFF, 3'b110};
    vt[11] = '{itype(6'h04, 5'd2, 5'd3, 16'h0000), 8'h03, 1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 8'h03, 3'b110};
    vt[12] = '{itype(6'h04, 5'd3, 5'd2, 16'h0000), 8'h03, 1'b1, 1'b0, 32'd10, 1'b1, 1'b1, 8'h03, 3'b110};
    vt[13] = '{itype(6'h3f, 5'd1, 5'd2, 16'h1234), 8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h34, 3'b000};
    vt[14] = '{itype(6'h08, 5'd1, 5'd2, 16'hFF80), 8'h90, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h10, 3'b010};
    vt[15] = '{itype(6'h04, 5'd2, 5'd2, 16'h0000), 8'h00, 1'b1, 1'b0, 32'd11, 1'b1, 1'b0, 8'h00, 3'b110};

    for (int i = 0; i < 16; i++) begin
      InstrD = vt[i].ins; PCPlus1D = vt[i].pc;
      ForwardAD = vt[i].fa; ForwardBD = vt[i].fb; ALUOutM = vt[i].alu;
      #1;
      chk($sformatf("vec%0d.BranchD", i), 32'(BranchD), 32'(vt[i].br));
      chk($sformatf("vec%0d.PCSrcD", i), 32'(PCSrcD), 32'(vt[i].src));
      chk($sformatf("vec%0d.PCBranchD", i), 32'(PCBranchD), 32'(vt[i].pcb));
      chk($sformatf("vec%0d.ALUControlD", i), 32'(ALUControlD), 32'(vt[i].ctl));
      tick();
      checkE($sformatf("vec%0d", i));
    end

    for (int n = 0; n < 400; n++) begin
      logic [5:0] o;
      case ($urandom_range(0, 5))
        0: o = 6'h00;
        1: o = 6'h23;
        2: o = 6'h2b;
        3: o = 6'h04;
        4: o = 6'h08;
        default: o = 6'($urandom_range(0, 63));
      endcase
      InstrD = $urandom;
      InstrD[31:26] = o;
      InstrD[25:21] = 5'($urandom_range(0, 7));
      InstrD[20:16] = 5'($urandom_range(0, 7));
      InstrD[15:11] = 5'($urandom_range(0, 7));
      if (o == 6'h00) InstrD[5:0] = fns[$urandom_range(0, 6)];
      PCPlus1D  = 8'($urandom);
      RegWriteW = 1'($urandom);
      WriteRegW = 5'($urandom_range(0, 7));
      ResultW   = $urandom;
      ForwardAD = 1'($urandom);
      ForwardBD = 1'($urandom);
      ALUOutM   = ($urandom_range(0, 1) == 1) ? mRead(InstrD[20:16]) : $urandom;
      FlushE    = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 39) == 0);
      #1;
      checkD($sformatf("rnd%0d", n));
      tick();
      checkE($sformatf("rnd%0d", n));
    end

    reset = 1'b1; FlushE = 1'b1;
    InstrD = rtype(5'd5, 5'd2, 5'd3, 6'h20);
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h1234;
    tick();
    checkE("rstFlush");
    chk("rstFlush.RegWriteE", 32'(RegWriteE), 32'd0);
    chk("rstFlush.RsE", 32'(RsE), 32'd0);
    reset = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0;
    tick();
    chk("rstFlush.RD1E", RD1E, 32'd0);
    chk("rstFlush.RsE2", 32'(RsE), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
